// File: rtl/lsu_ctrl.sv
// Load/store unit sequencer between the pipeline handshake and a single-port data memory.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses; otherwise they are aligned down.
module lsu_ctrl #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  dm_MemRead,
  output logic                  dm_MemWrite,
  output logic [DM_ADDRESS-1:0] dm_a,
  output logic [DATA_W-1:0]     dm_wd,
  output logic [2:0]            dm_Funct3,
  input  logic [DATA_W-1:0]     dm_rd
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready=1
  // RD    | memory read strobe (load, or first half of SH read-modify-write)
  // WR    | memory write strobe
  // RESP  | response held until resp_ready
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t state, state_nx;

  logic                  we_q;
  logic [2:0]            f3_q;
  logic [DM_ADDRESS-1:0] a_q;
  logic [DATA_W-1:0]     wd_q;
  logic                  err_q;
  logic [DATA_W-1:0]     rd_q;

  logic                  accept;
  logic                  is_word, is_half, bad_f3, misal, range_err, mis_err, req_err;
  logic [DM_ADDRESS-1:0] addr_al;
  logic                  lhu_q, sh_q;
  logic [DM_ADDRESS-1:0] word_a;
  logic [DATA_W-1:0]     lhu_ext, merged;

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    is_word   = (req_funct3 == F3_W);
    is_half   = (req_funct3 == F3_H) || (!req_we && req_funct3 == F3_HU);
    if (req_we)
      bad_f3 = !((req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W));
    else
      bad_f3 = !((req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                 (req_funct3 == F3_BU) || (req_funct3 == F3_HU));
    misal     = (is_word && (req_addr[1:0] != 2'b00)) || (is_half && req_addr[0]);
    range_err = |req_addr[31:DM_ADDRESS];
    addr_al   = req_addr[DM_ADDRESS-1:0];
    if (is_word)
      addr_al[1:0] = 2'b00;
    else if (is_half)
      addr_al[0] = 1'b0;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_err = misal;
`else
  assign mis_err = 1'b0;
`endif

  assign req_err = range_err || bad_f3 || mis_err;

  // LHU and SH are served with full-word memory accesses
  assign lhu_q  = !we_q && (f3_q == F3_HU);
  assign sh_q   = we_q && (f3_q == F3_H);
  assign word_a = {a_q[DM_ADDRESS-1:2], 2'b00};

  always_comb begin
    lhu_ext       = '0;
    lhu_ext[15:0] = a_q[1] ? dm_rd[31:16] : dm_rd[15:0];
    merged        = rd_q;
    if (a_q[1])
      merged[31:16] = wd_q[15:0];
    else
      merged[15:0]  = wd_q[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      we_q  <= 1'b0;
      f3_q  <= '0;
      a_q   <= '0;
      wd_q  <= '0;
      err_q <= 1'b0;
      rd_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q  <= req_we;
        f3_q  <= req_funct3;
        a_q   <= addr_al;
        wd_q  <= req_wdata;
        err_q <= req_err;
        rd_q  <= '0;
      end else if (state == RD) begin
        rd_q <= lhu_q ? lhu_ext : dm_rd;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = '0;
    dm_MemRead  = 1'b0;
    dm_MemWrite = 1'b0;
    dm_a        = '0;
    dm_wd       = '0;
    dm_Funct3   = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)
            state_nx = RESP;
          else if (req_we && req_funct3 != F3_H)
            state_nx = WR;
          else
            state_nx = RD;
        end
      end
      RD: begin
        dm_MemRead = 1'b1;
        dm_a       = (lhu_q || sh_q) ? word_a : a_q;
        dm_Funct3  = (lhu_q || sh_q) ? F3_W : f3_q;
        state_nx   = sh_q ? WR : RESP;
      end
      WR: begin
        dm_MemWrite = 1'b1;
        dm_a        = sh_q ? word_a : a_q;
        dm_Funct3   = sh_q ? F3_W : f3_q;
        dm_wd       = sh_q ? merged : wd_q;
        state_nx    = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q || err_q) ? '0 : rd_q;
        if (resp_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: byte-addressed memory model, vector table and corner sequences.
// Expectations for misaligned accesses follow LSU_MISALIGN_TRAP_EN.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dm_MemRead, dm_MemWrite;
  logic [8:0]  dm_a;
  logic [31:0] dm_wd;
  logic [2:0]  dm_Funct3;
  logic [31:0] dm_rd;

  lsu_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite), .dm_a(dm_a),
    .dm_wd(dm_wd), .dm_Funct3(dm_Funct3), .dm_rd(dm_rd)
  );

  always #5 clk = ~clk;

  // Little-endian byte memory; reads decode the access type like the real data memory
  logic [7:0]  mem [0:511];
  logic [31:0] mw;
  always_comb begin
    mw    = {mem[9'(dm_a + 9'd3)], mem[9'(dm_a + 9'd2)], mem[9'(dm_a + 9'd1)], mem[dm_a]};
    dm_rd = '0;
    case (dm_Funct3)
      3'b000:  dm_rd = {{24{mw[7]}}, mw[7:0]};
      3'b001:  dm_rd = {{16{mw[15]}}, mw[15:0]};
      3'b010:  dm_rd = mw;
      3'b100:  dm_rd = {24'h0, mw[7:0]};
      3'b101:  dm_rd = {16'h0, mw[15:0]};
      default: dm_rd = '0;
    endcase
  end

  always @(posedge clk) begin
    if (dm_MemWrite) begin
      mem[dm_a] = dm_wd[7:0];
      if (dm_Funct3 != 3'b000) mem[9'(dm_a + 9'd1)] = dm_wd[15:8];
      if (dm_Funct3 == 3'b010) begin
        mem[9'(dm_a + 9'd2)] = dm_wd[23:16];
        mem[9'(dm_a + 9'd3)] = dm_wd[31:24];
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;
  int nrd = 0, nwr = 0;
  logic [8:0] last_a = '0;
  logic [2:0] last_f3 = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (dm_MemRead) nrd++;
      if (dm_MemWrite) nwr++;
      if (dm_MemRead || dm_MemWrite) begin
        last_a  = dm_a;
        last_f3 = dm_Funct3;
      end
      if (dm_MemRead && dm_MemWrite) begin
        n_bad++;
        $display("FAIL strobe_excl: got rd=1 wr=1 expected at most one");
      end
      if (!dm_MemRead && !dm_MemWrite && (dm_a != 0 || dm_wd != 0 || dm_Funct3 != 0)) begin
        n_bad++;
        $display("FAIL idle_dm_zero: got a=%h wd=%h f3=%h expected all 0", dm_a, dm_wd, dm_Funct3);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [8:0]  a;
    logic [2:0]  f3m;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                     input int lat, input int r, input int w, input logic [8:0] a,
                     input logic [2:0] f3m);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
    v.lat = lat; v.nrd = r; v.nwr = w; v.a = a; v.f3m = f3m;
    vecs.push_back(v);
  endtask

  // Issue one request, measure latency, optionally hold resp_ready low for `hold` cycles
  task automatic run(input vec_t v, input int hold, input string tag);
    int lat;
    bit done;
    logic [31:0] rd0;
    logic        er0;
    @(negedge clk);
    nrd = 0;
    nwr = 0;
    resp_ready = (hold == 0);
    req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (i > 0) @(posedge clk);
      if (i > 0) #1;
      lat++;
      if (resp_valid) done = 1;
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s timeout: got no resp_valid expected within 10 cycles", tag);
      resp_ready = 1'b1;
      return;
    end
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " rdata"}, resp_rdata, v.rdata);
    chk({tag, " err"}, resp_err, v.err);
    chk({tag, " n_rd"}, nrd, v.nrd);
    chk({tag, " n_wr"}, nwr, v.nwr);
    if (v.nrd + v.nwr > 0) begin
      chk({tag, " dm_a"}, last_a, v.a);
      chk({tag, " dm_f3"}, last_f3, v.f3m);
    end
    if (hold > 0) begin
      rd0 = resp_rdata;
      er0 = resp_err;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk({tag, " hold valid"}, resp_valid, 1);
        chk({tag, " hold rdata"}, resp_rdata, rd0);
        chk({tag, " hold err"}, resp_err, er0);
        chk({tag, " hold ready"}, req_ready, 0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, " post valid"}, resp_valid, 0);
      chk({tag, " post ready"}, req_ready, 1);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  vec_t hv;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;

    add(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 9'h10, 3'b010);
    add(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 9'h10, 3'b010);
    add(1, 3'b010, 32'h20,  32'h11223344, 32'h0,        0, 2, 0, 1, 9'h20, 3'b010);
    add(1, 3'b001, 32'h22,  32'h0000AAAA, 32'h0,        0, 3, 1, 1, 9'h20, 3'b010);
    add(0, 3'b010, 32'h20,  32'h0,        32'hAAAA3344, 0, 2, 1, 0, 9'h20, 3'b010);
    add(1, 3'b010, 32'h30,  32'h8001FFFE, 32'h0,        0, 2, 0, 1, 9'h30, 3'b010);
    add(0, 3'b101, 32'h32,  32'h0,        32'h00008001, 0, 2, 1, 0, 9'h30, 3'b010);
    add(0, 3'b001, 32'h30,  32'h0,        32'hFFFFFFFE, 0, 2, 1, 0, 9'h30, 3'b001);
    add(0, 3'b101, 32'h30,  32'h0,        32'h0000FFFE, 0, 2, 1, 0, 9'h30, 3'b010);
    add(0, 3'b000, 32'h31,  32'h0,        32'hFFFFFFFF, 0, 2, 1, 0, 9'h31, 3'b000);
    add(0, 3'b100, 32'h33,  32'h0,        32'h00000080, 0, 2, 1, 0, 9'h33, 3'b100);
    add(1, 3'b000, 32'h12,  32'h00000055, 32'h0,        0, 2, 0, 1, 9'h12, 3'b000);
    add(0, 3'b010, 32'h10,  32'h0,        32'hDE55BEEF, 0, 2, 1, 0, 9'h10, 3'b010);
    add(1, 3'b001, 32'h20,  32'h12345678, 32'h0,        0, 3, 1, 1, 9'h20, 3'b010);
    add(0, 3'b010, 32'h20,  32'h0,        32'hAAAA5678, 0, 2, 1, 0, 9'h20, 3'b010);
    add(0, 3'b010, 32'h200, 32'h0,        32'h0,        1, 1, 0, 0, 9'h0,  3'b000);
    add(0, 3'b011, 32'h10,  32'h0,        32'h0,        1, 1, 0, 0, 9'h0,  3'b000);
    add(0, 3'b110, 32'h10,  32'h0,        32'h0,        1, 1, 0, 0, 9'h0,  3'b000);
    add(1, 3'b100, 32'h10,  32'h12345678, 32'h0,        1, 1, 0, 0, 9'h0,  3'b000);
    add(0, 3'b010, 32'h80000010, 32'h0,   32'h0,        1, 1, 0, 0, 9'h0,  3'b000);
    add(0, 3'b010, 32'h1FC, 32'h0,        32'h0,        0, 2, 1, 0, 9'h1FC, 3'b010);
    add(1, 3'b010, 32'h40,  32'hCAFEF00D, 32'h0,        0, 2, 0, 1, 9'h40, 3'b010);
`ifdef LSU_MISALIGN_TRAP_EN
    add(0, 3'b010, 32'h41,  32'h0,        32'h0,        1, 1, 0, 0, 9'h0,  3'b000);
    add(0, 3'b001, 32'h33,  32'h0,        32'h0,        1, 1, 0, 0, 9'h0,  3'b000);
    add(0, 3'b101, 32'h31,  32'h0,        32'h0,        1, 1, 0, 0, 9'h0,  3'b000);
    add(1, 3'b010, 32'h46,  32'h0BADCAFE, 32'h0,        1, 1, 0, 0, 9'h0,  3'b000);
    add(0, 3'b010, 32'h44,  32'h0,        32'h00000000, 0, 2, 1, 0, 9'h44, 3'b010);
`else
    add(0, 3'b010, 32'h41,  32'h0,        32'hCAFEF00D, 0, 2, 1, 0, 9'h40, 3'b010);
    add(0, 3'b001, 32'h33,  32'h0,        32'hFFFF8001, 0, 2, 1, 0, 9'h32, 3'b001);
    add(0, 3'b101, 32'h31,  32'h0,        32'h0000FFFE, 0, 2, 1, 0, 9'h30, 3'b010);
    add(1, 3'b010, 32'h46,  32'h0BADCAFE, 32'h0,        0, 2, 0, 1, 9'h44, 3'b010);
    add(0, 3'b010, 32'h44,  32'h0,        32'h0BADCAFE, 0, 2, 1, 0, 9'h44, 3'b010);
`endif

    #12;
    chk("rst req_ready", req_ready, 1);
    chk("rst resp_valid", resp_valid, 0);
    chk("rst resp_err", resp_err, 0);
    chk("rst resp_rdata", resp_rdata, 0);
    chk("rst strobes", {30'h0, dm_MemRead, dm_MemWrite}, 0);
    chk("rst dm_a", dm_a, 0);
    chk("rst dm_wd", dm_wd, 0);
    chk("rst dm_f3", dm_Funct3, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) run(vecs[i], 0, $sformatf("vec%0d", i));

    // Backpressure on an out-of-range fault and on a good load
    hv = '{we:0, f3:3'b010, addr:32'h200, wdata:0, rdata:0, err:1, lat:1, nrd:0, nwr:0, a:0, f3m:0};
    run(hv, 5, "bp_fault");
    hv = '{we:0, f3:3'b010, addr:32'h10, wdata:0, rdata:32'hDE55BEEF, err:0, lat:2, nrd:1, nwr:0,
           a:9'h10, f3m:3'b010};
    run(hv, 5, "bp_load");

    // Reset during the read phase of SH must abort it with no write
    @(negedge clk);
    nrd = 0;
    nwr = 0;
    req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h22; req_wdata = 32'h0000FFFF;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("rstmid in_rd", dm_MemRead, 1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid rd_drop", dm_MemRead, 0);
    chk("rstmid wr_drop", dm_MemWrite, 0);
    chk("rstmid ready", req_ready, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rstmid no_write", nwr, 0);
    chk("rstmid ready_after", req_ready, 1);
    chk("rstmid no_resp", resp_valid, 0);
    hv = '{we:0, f3:3'b010, addr:32'h20, wdata:0, rdata:32'hAAAA5678, err:0, lat:2, nrd:1, nwr:0,
           a:9'h20, f3m:3'b010};
    run(hv, 0, "rstmid_mem");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have parameter DM_ADDRESS, default 9: width of the data-memory byte address.
REQ-002 The block SHALL have parameter DATA_W, default 32: data width.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid / req_ready  in / out  1  request handshake from the pipeline.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_funct3  in  3  RISC-V load/store funct3.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  DATA_W  store data.
REQ-011 resp_valid / resp_ready  out / in  1  response handshake.
REQ-012 resp_rdata  out  DATA_W  load result, 0 for stores and errors.
REQ-013 resp_err  out  1  access fault.
REQ-014 dm_MemRead, dm_MemWrite  out  1  data-memory strobes.
REQ-015 dm_a  out  DM_ADDRESS  data-memory address.
REQ-016 dm_wd  out  DATA_W  data-memory write data.
REQ-017 dm_Funct3  out  3  data-memory access type.
REQ-018 dm_rd  in  DATA_W  data-memory read data (combinational).

Function
REQ-019 The FSM SHALL have states IDLE, RD, WR and RESP, and all outputs SHALL be decoded from registered state and latched request fields.
REQ-020 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge with req_valid&&req_ready, and all request fields SHALL be latched then.
REQ-021 Error check at accept: resp_err SHALL be set if req_addr[31:DM_ADDRESS]!=0, or the funct3 is unsupported (loads 011/110/111; stores other than 000/001/010), or the access is misaligned (see REQ-035).
REQ-022 On error: IDLE->RESP, no memory strobe ever asserted, resp_rdata=0.
REQ-023 LW/LB/LH/LBU: IDLE->RD->RESP; in RD, dm_MemRead=1, dm_a=addr, dm_Funct3=funct3, and dm_rd SHALL be captured into resp_rdata at the edge leaving RD.
REQ-024 LHU (101): handled locally; RD SHALL issue dm_Funct3=010 with dm_a={addr[8:2],00}, and the captured result SHALL be the zero-extended halfword selected by addr[1].
REQ-025 SW/SB: IDLE->WR->RESP; in WR, dm_MemWrite=1, dm_a=addr, dm_Funct3=funct3, dm_wd=req_wdata.
REQ-026 SH (001): read-modify-write, IDLE->RD->WR->RESP.
  - RD SHALL read the word with dm_Funct3=010 and latch it.
  - WR SHALL write dm_Funct3=010 with wdata[15:0] merged into half addr[1] and the other half preserved.
REQ-027 dm_MemRead and dm_MemWrite SHALL never both be 1; outside RD/WR, both strobes SHALL be 0 and dm_a, dm_wd, dm_Funct3 SHALL be 0.
REQ-028 In RESP, resp_valid SHALL be 1 and SHALL hold until resp_valid&&resp_ready, then the FSM SHALL return to IDLE; resp_rdata and resp_err SHALL be stable while resp_valid=1.
REQ-029 A new request SHALL be accepted no earlier than the cycle after the response handshake; there is no back-to-back overlap.
REQ-030 Latencies from the accept edge to resp_valid rising: error 1 cycle; load/SW/SB 2 cycles; SH 3 cycles.

Reset
REQ-031 While reset=1: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, all dm_* outputs=0.
REQ-032 Reset asserted mid-operation SHALL drop the strobes immediately (asynchronously) and discard the pending request; no partial SH write SHALL be issued after release.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN SHALL select misalignment handling.
REQ-034 Misalignment definition: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0.
REQ-035 With LSU_MISALIGN_TRAP_EN defined, a misaligned access SHALL be an error per REQ-021/022.
REQ-036 Without LSU_MISALIGN_TRAP_EN, a misaligned access SHALL be aligned down (word: addr[1:0]=00; half: addr[0]=0), proceed normally, and return resp_err=0.

Verification
REQ-037 Store/load: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, 2-cycle latency each.
REQ-038 SH read-modify-write: memory word 0x11223344 at 0x20; SH addr 0x22 data 0xAAAA; LW 0x20 -> 0xAAAA3344; exactly one dm_MemWrite pulse; latency 3.
REQ-039 LHU/LH: word 0x8001FFFE at 0x30; LHU 0x32 -> 0x00008001; LH 0x30 -> 0xFFFFFFFE.
REQ-040 Misaligned LW 0x41:
  - Trap macro defined: resp_err=1, resp_rdata=0, no strobe.
  - Macro undefined: returns the word at 0x40, resp_err=0.
REQ-041 Faults and backpressure: LW 0x200 -> resp_err=1 with no strobe; hold resp_ready=0 for 5 cycles -> resp_valid and data held stable and req_ready=0 throughout.
REQ-042 Reset mid-SH: assert reset during RD -> strobes 0 immediately; after release, memory at the target word is unchanged and req_ready=1.
